// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle multiply/divide unit with HI/LO result registers.
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin a new operation (honoured only when idle and not cancelled)
//   op       : 00 mult, 01 multu, 10 div, 11 divu
//   rs_data  : multiplicand / dividend
//   rt_data  : multiplier / divisor
//   cancel   : abort the in-flight operation; hi/lo keep their old values
//   busy     : operation in flight
//   done     : one-cycle pulse, hi/lo carry the new result in the same cycle
//   hi / lo  : product[63:32] / product[31:0], or remainder / quotient
module muldiv_unit #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [DataWidth-1:0] rs_data,
  input  logic [DataWidth-1:0] rt_data,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] hi,
  output logic [DataWidth-1:0] lo
);

  localparam int unsigned W    = DataWidth;
  localparam int unsigned CntW = $clog2(DataWidth);
  localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;

  logic [1:0]      state, state_d;
  logic [CntW-1:0] cnt;
  logic            is_div;
  logic            sign_a, sign_b;
  logic [W-1:0]    acc;   // product high half / partial remainder
  logic [W-1:0]    wq;    // multiplier bits shifting out, product low half / quotient
  logic [W-1:0]    opb;   // multiplicand magnitude / divisor magnitude

  logic            op_signed;
  logic [W-1:0]    rs_abs, rt_abs;
  logic [W:0]      add_sum, trial;
  logic            trial_ge;
  logic [W-1:0]    acc_sub;
  logic [W-1:0]    acc_n, wq_n;
  logic [2*W-1:0]  prod, prod_fix;
  logic [W-1:0]    q_fix, r_fix;
  logic [W-1:0]    res_hi, res_lo;

  // Operand magnitudes for signed ops, raw operands for unsigned ones
  always_comb begin
    op_signed = ~op[0];
    rs_abs    = (op_signed && rs_data[W-1]) ? W'(-rs_data) : rs_data;
    rt_abs    = (op_signed && rt_data[W-1]) ? W'(-rt_data) : rt_data;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    add_sum  = {1'b0, acc} + (wq[0] ? {1'b0, opb} : (W+1)'(0));
    trial    = {acc, wq[W-1]};
    trial_ge = (trial >= {1'b0, opb});
    // Remainder stays below the divisor, so the W-bit difference is exact
    acc_sub  = trial[W-1:0] - opb;
    if (!is_div) begin
      acc_n = add_sum[W:1];
      wq_n  = {add_sum[0], wq[W-1:1]};
    end else if (trial_ge) begin
      acc_n = acc_sub;
      wq_n  = {wq[W-2:0], 1'b1};
    end else begin
      acc_n = trial[W-1:0];
      wq_n  = {wq[W-2:0], 1'b0};
    end
  end

  // Sign correction of the final magnitudes
  always_comb begin
    prod     = {acc, wq};
    prod_fix = (sign_a ^ sign_b) ? (2*W)'(-prod) : prod;
    q_fix    = (sign_a ^ sign_b) ? W'(-wq) : wq;
    r_fix    = sign_a ? W'(-acc) : acc;
    // Divide by zero: all-ones quotient regardless of dividend sign
    if (opb == '0) begin
      q_fix = '1;
    end
    if (is_div) begin
      res_hi = r_fix;
      res_lo = q_fix;
    end else begin
      res_hi = prod_fix[2*W-1:W];
      res_lo = prod_fix[W-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start && !cancel) state_d = CALC;
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt == CntLast) begin
          state_d = SIGN;
        end
      end
      SIGN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      wq     <= '0;
      opb    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            is_div <= op[1];
            sign_a <= op_signed & rs_data[W-1];
            sign_b <= op_signed & rt_data[W-1];
            acc    <= '0;
            wq     <= rs_abs;
            opb    <= rt_abs;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (!cancel) begin
            acc <= acc_n;
            wq  <= wq_n;
            cnt <= cnt + CntW'(1);
          end
        end
        SIGN: begin
          if (!cancel) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DataWidth, default 32, operand and HI/LO width; all values below assume 32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 rs_data  in  32  multiplicand / dividend.
REQ-007 rt_data  in  32  multiplier / divisor.
REQ-008 cancel  in  1  abort the in-flight operation (pipeline flush).
REQ-009 busy  out  1  operation in flight; decode stalls mfhi/mflo/mult/div while high.
REQ-010 done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
REQ-011 hi  out  32  HI register: product[63:32] or remainder.
REQ-012 lo  out  32  LO register: product[31:0] or quotient.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and SIGN, with a 5-bit iteration counter.
REQ-014 IDLE with start=1 SHALL latch op, the absolute values of the operands (signed ops) or the raw operands (unsigned ops), and both operand signs, then go to CALC with counter=0 and busy=1.
REQ-015 CALC SHALL perform one iteration per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide; each iteration uses a 33-bit intermediate.
REQ-016 CALC SHALL go to SIGN after the iteration with counter=31, for exactly 32 iterations.
REQ-017 SIGN SHALL apply the sign correction, write hi/lo, assert done for one cycle, deassert busy and return to IDLE, all on the same edge.
REQ-018 Latency SHALL be fixed: with start sampled at edge E0, done and the new hi/lo are visible after edge E33; busy is high after edges E0..E32.
REQ-019 Signed multiply SHALL negate the 64-bit product when the operand signs differ.
REQ-020 Signed divide SHALL negate the quotient when the signs differ, and SHALL give the remainder the sign of the dividend.
REQ-021 Divide by zero SHALL still take the full latency and SHALL produce lo=0xFFFFFFFF, hi=dividend; no exception is raised.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0.
REQ-023 start SHALL be ignored while busy=1, with no queuing.
REQ-024 cancel=1 in CALC or SIGN SHALL return the FSM to IDLE on the next edge, with hi/lo unchanged and no done pulse; cancel in IDLE SHALL have no effect.
REQ-025 If cancel and start are both high in IDLE, cancel SHALL win and no operation starts.
REQ-026 hi/lo SHALL change only in SIGN or on reset, and SHALL hold their values indefinitely otherwise.

Reset
REQ-027 rst=1 SHALL override all other inputs on that edge: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0.
REQ-028 rst asserted mid-operation SHALL discard the operation, with no done pulse afterward.

Verification
REQ-029 mult, rs=0xFFFFFFFE, rt=3 -> done after E33, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 multu, rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-031 div, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 divu, rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5 after E33.
REQ-033 multu 3x4 completed, then a new mult started with cancel=1 at E10 -> busy=0 after E10, no done, hi=0, lo=12 retained; start pulsed at E5 is ignored.
REQ-034 rst=1 at E20 of a div -> all outputs 0 next cycle and no done; a new start at E22 completes normally after E55.
